// File: rtl/f_fetch_queue_if.sv
// Fetch/decode handshake bundle around the instruction prefetch queue.
// master: the pipeline side (PC register + decode); slave: the queue itself.
interface f_fetch_queue_if;
    // Fetch side
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_valid;
    logic        f_ifu_en;

    // Redirect
    logic        flush;

    // Decode side
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_exc_adel;

    modport master (
        output f_pc, f_instr, f_valid, flush, d_ready,
        input  f_ifu_en, d_valid, d_pc, d_instr, d_exc_adel
    );

    modport slave (
        input  f_pc, f_instr, f_valid, flush, d_ready,
        output f_ifu_en, d_valid, d_pc, d_instr, d_exc_adel
    );
endinterface

// File: rtl/f_fetch_queue.sv
// Instruction prefetch queue between the PC register and decode: captures
// {PC, instr, AdEL} per fetch, hands the oldest entry to decode, flushes on redirect.

// One queue slot: payload register plus its valid bit.
module f_fetch_queue_entry #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [W-1:0] wr_data,
    output logic         vld,
    output logic [W-1:0] data
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (flush) begin
            vld  <= 1'b0;
        end else begin
            // Push never targets the head while it is being popped, so order is free
            if (rd_en) vld <= 1'b0;
            if (wr_en) begin
                vld  <= 1'b1;
                data <= wr_data;
            end
        end
    end
endmodule

module f_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter logic [31:0] TEXT_END  = 32'h0000_6FFC
) (
    input  logic                     clk,
    input  logic                     reset,
    f_fetch_queue_if.slave           bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fq_entry_t;

    localparam int EW = $bits(fq_entry_t);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("f_fetch_queue: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [PW-1:0]               rd_ptr, wr_ptr;
    logic                        full, empty;
    logic                        push, pop;
    logic                        adel;
    fq_entry_t                   wr_ent, head;
    logic [DEPTH-1:0]            ent_vld;
    logic [DEPTH-1:0][EW-1:0]    ent_data;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Registered-state only: no combinational path from d_ready or flush
    assign bus.f_ifu_en = !full;

    assign adel = (bus.f_pc[1:0] != 2'b00) || (bus.f_pc < TEXT_BASE) || (bus.f_pc > TEXT_END);

    assign push = bus.f_valid && !full && !bus.flush;
    assign pop  = bus.d_valid && bus.d_ready && !bus.flush;

    always_comb begin
        wr_ent.pc    = bus.f_pc;
        wr_ent.instr = adel ? 32'h0 : bus.f_instr;
        wr_ent.adel  = adel;
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_ent
            f_fetch_queue_entry #(.W(EW)) u_ent (
                .clk     (clk),
                .reset   (reset),
                .flush   (bus.flush),
                .wr_en   (push && (wr_ptr == PW'(g))),
                .rd_en   (pop && (rd_ptr == PW'(g))),
                .wr_data (wr_ent),
                .vld     (ent_vld[g]),
                .data    (ent_data[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is zeroed whenever the slot is empty so decode never sees stale data
    always_comb begin
        head = fq_entry_t'(ent_data[rd_ptr]);
        if (!ent_vld[rd_ptr]) head = '0;
    end

    assign bus.d_valid    = ent_vld[rd_ptr] && !empty;
    assign bus.d_pc       = head.pc;
    assign bus.d_instr    = head.instr;
    assign bus.d_exc_adel = head.adel;
endmodule

// File: tb/tb_f_fetch_queue.sv
// Directed bench for f_fetch_queue: fill/drain, streaming wrap, flush, AdEL, async reset.
module tb_f_fetch_queue;
    logic       clk;
    logic       reset;
    logic [2:0] count;
    int         n_chk;
    int         n_pass;

    f_fetch_queue_if bus ();

    f_fetch_queue #(
        .DEPTH     (4),
        .TEXT_BASE (32'h0000_3000),
        .TEXT_END  (32'h0000_6FFC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        bus.f_valid = fv;
        bus.f_pc    = pc;
        bus.f_instr = ins;
        bus.d_ready = rdy;
        bus.flush   = fl;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
        chk("rst_d_pc", bus.d_pc, 32'h0);
        chk("rst_d_instr", bus.d_instr, 32'h0);
        chk("rst_d_exc", 32'(bus.d_exc_adel), 32'd0);
        chk("rst_ifu_en", 32'(bus.f_ifu_en), 32'd1);
        chk("rst_count", 32'(count), 32'd0);

        // Fill to full with decode stalled
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
            tick();
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        chk("fill_ifu_en", 32'(bus.f_ifu_en), 32'd0);
        chk("fill_head_pc", bus.d_pc, 32'h3000);
        chk("fill_head_instr", bus.d_instr, 32'h1000_0000);

        // 5th push while full is dropped
        drive(1'b1, 32'h3010, 32'h1000_0004, 1'b0, 1'b0);
        tick();
        chk("full_count", 32'(count), 32'd4);
        chk("full_head_pc", bus.d_pc, 32'h3000);

        // Drain in order
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(bus.d_valid), 32'd1);
            chk("drain_pc", bus.d_pc, 32'h3000 + 32'(4 * i));
            tick();
            if (i == 0) begin
                chk("drain_ifu_en", 32'(bus.f_ifu_en), 32'd1);
                chk("drain_count3", 32'(count), 32'd3);
            end
        end
        chk("drain_empty_valid", 32'(bus.d_valid), 32'd0);
        chk("drain_empty_count", 32'(count), 32'd0);
        chk("drain_empty_pc", bus.d_pc, 32'h0);

        // Streaming push+pop with pointer wrap
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h3000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b1, 1'b0);
            tick();
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_pc", bus.d_pc, 32'h3000 + 32'(4 * k));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("stream_end_count", 32'(count), 32'd0);

        // Flush with a coincident push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        chk("preflush_count", 32'(count), 32'd3);
        drive(1'b1, 32'h3020, 32'hC000_0000, 1'b1, 1'b1);
        tick();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(bus.d_valid), 32'd0);
        chk("flush_ifu_en", 32'(bus.f_ifu_en), 32'd1);
        drive(1'b1, 32'h3040, 32'hC000_0040, 1'b0, 1'b0);
        tick();
        chk("redirect_count", 32'(count), 32'd1);
        chk("redirect_pc", bus.d_pc, 32'h3040);
        chk("redirect_instr", bus.d_instr, 32'hC000_0040);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("redirect_drain", 32'(count), 32'd0);

        // Address errors: misaligned, then above text end
        drive(1'b1, 32'h3002, 32'h2408_0001, 1'b0, 1'b0);
        tick();
        chk("adel_mis_valid", 32'(bus.d_valid), 32'd1);
        chk("adel_mis_pc", bus.d_pc, 32'h3002);
        chk("adel_mis_exc", 32'(bus.d_exc_adel), 32'd1);
        chk("adel_mis_instr", bus.d_instr, 32'h0);
        drive(1'b1, 32'h7000, 32'h2408_0001, 1'b0, 1'b0);
        tick();
        // Pop the misaligned one while pushing a legal fetch
        drive(1'b1, 32'h3000, 32'h2408_0001, 1'b1, 1'b0);
        tick();
        chk("adel_hi_count", 32'(count), 32'd2);
        chk("adel_hi_pc", bus.d_pc, 32'h7000);
        chk("adel_hi_exc", 32'(bus.d_exc_adel), 32'd1);
        chk("adel_hi_instr", bus.d_instr, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("legal_pc", bus.d_pc, 32'h3000);
        chk("legal_exc", 32'(bus.d_exc_adel), 32'd0);
        chk("legal_instr", bus.d_instr, 32'h2408_0001);
        tick();

        // Inclusive text-end boundary is legal; just below base is not
        drive(1'b1, 32'h6FFC, 32'h0000_AAAA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h2FFC, 32'h0000_BBBB, 1'b0, 1'b0);
        tick();
        chk("end_exc", 32'(bus.d_exc_adel), 32'd0);
        chk("end_instr", bus.d_instr, 32'h0000_AAAA);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("below_exc", 32'(bus.d_exc_adel), 32'd1);
        chk("below_instr", bus.d_instr, 32'h0);
        tick();
        chk("bound_drain", 32'(count), 32'd0);

        // Async reset between edges
        drive(1'b1, 32'h3200, 32'hD000_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3204, 32'hD000_0001, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("prerst_count", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.d_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ifu_en", 32'(bus.f_ifu_en), 32'd1);
        chk("arst_pc", bus.d_pc, 32'h0);
        #10;
        reset = 1'b0;
        #10;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
